slice_scheduler: RTL and testbench



---
 rtl/slice_scheduler_pkg.sv | 16 +
 rtl/slice_scheduler_hall_edge_detector.sv | 27 ++
 rtl/slice_scheduler.sv | 140 ++++++++++++++
 tb/tb_slice_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_scheduler_pkg.sv
// Shared types and constants for the slice scheduler.
package slice_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam int OVERRUN_W = 16;

    function automatic int SLICE_IDX_W(input int nb_slices);
        return $clog2(nb_slices);
    endfunction

endpackage

// File: rtl/slice_scheduler_hall_edge_detector.sv
// Two-flop synchroniser for the raw hall input followed by a registered rising-edge detector.
module hall_edge_detector (
    input  logic clk,
    input  logic nrst,
    input  logic hall_sensor,
    output logic hall_rise
);

    logic sync_meta;
    logic sync_stable;
    logic sync_prev;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
            hall_rise   <= 1'b0;
        end else begin
            sync_meta   <= hall_sensor;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
            hall_rise   <= sync_stable & ~sync_prev;
        end
    end

endmodule

// File: rtl/slice_scheduler.sv
// Splits each measured rotor revolution into NB_SLICES position_sync pulses using an error accumulator.
// Optional macro SLICE_SCHEDULER_PHASE_OFFSET_EN adds a per-revolution phase_offset applied to slice_index.
module slice_scheduler
    import slice_scheduler_pkg::*;
#(
    parameter int NB_SLICES  = 128,
    parameter int PERIOD_W   = 24,
    parameter int MIN_PERIOD = 1024,
    parameter int MAX_PERIOD = 2**24 - 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         hall_sensor,
    input  logic                         slice_done,
`ifdef SLICE_SCHEDULER_PHASE_OFFSET_EN
    input  logic [$clog2(NB_SLICES)-1:0] phase_offset,
`endif
    output logic                         position_sync,
    output logic [$clog2(NB_SLICES)-1:0] slice_index,
    output logic                         rotation_locked,
    output logic [PERIOD_W-1:0]          rotation_period,
    output logic [OVERRUN_W-1:0]         overrun_count
);

    localparam int                  IDX_W      = SLICE_IDX_W(NB_SLICES);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NB_SLICES - 1);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P      = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W:0]   SLICE_STEP = (PERIOD_W + 1)'(NB_SLICES);

    state_t              state;
    logic                hall_rise;
    logic                accept;
    logic                timeout;
    logic                to_idle;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PERIOD_W:0]   acc;
    logic [PERIOD_W:0]   acc_next;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    offset;
    logic [IDX_W-1:0]    offset_in;
    logic                busy;

    hall_edge_detector u_edge (
        .clk         (clk),
        .nrst        (nrst),
        .hall_sensor (hall_sensor),
        .hall_rise   (hall_rise)
    );

`ifdef SLICE_SCHEDULER_PHASE_OFFSET_EN
    assign offset_in = phase_offset;
`else
    assign offset_in = '0;
`endif

    assign acc_next    = acc + SLICE_STEP;
    assign accept      = hall_rise && (period_cnt >= MIN_P);
    assign timeout     = (period_cnt == MAX_P);
    assign to_idle     = (state != IDLE) && timeout;
    assign slice_index = idx + offset;

    // Timeout has priority over an edge arriving on the same cycle, so period_cnt never passes MAX_P.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= IDLE;
            period_cnt      <= '0;
            acc             <= '0;
            idx             <= '0;
            offset          <= '0;
            position_sync   <= 1'b0;
            rotation_locked <= 1'b0;
            rotation_period <= '0;
        end else begin
            position_sync <= 1'b0;
            case (state)
                IDLE: begin
                    if (hall_rise) begin
                        state      <= ACQUIRE;
                        period_cnt <= PERIOD_W'(1);
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (timeout) begin
                        state           <= IDLE;
                        rotation_locked <= 1'b0;
                        period_cnt      <= '0;
                        acc             <= '0;
                        idx             <= '0;
                        offset          <= '0;
                    end else if (accept) begin
                        state           <= LOCKED;
                        rotation_locked <= 1'b1;
                        rotation_period <= period_cnt;
                        period_cnt      <= PERIOD_W'(1);
                        acc             <= '0;
                        idx             <= '0;
                        offset          <= offset_in;
                        position_sync   <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                        // On the last slice the accumulator is frozen so a slow rotor cannot wrap it.
                        if (state == LOCKED) begin
                            if (acc_next >= {1'b0, rotation_period}) begin
                                if (idx != LAST_IDX) begin
                                    acc           <= acc_next - {1'b0, rotation_period};
                                    idx           <= idx + 1'b1;
                                    position_sync <= 1'b1;
                                end
                            end else begin
                                acc <= acc_next;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new slice wins over a simultaneous slice_done, so the driver is still seen as busy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy          <= 1'b0;
            overrun_count <= '0;
        end else begin
            if (to_idle) begin
                busy <= 1'b0;
            end else if (position_sync) begin
                busy <= 1'b1;
            end else if (slice_done) begin
                busy <= 1'b0;
            end
            if (position_sync && busy && (overrun_count != '1)) begin
                overrun_count <= overrun_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slice_scheduler.sv
// Bench for slice_scheduler: random hall periods checked against a slice-timing model built from revolution lengths.
module tb_slice_scheduler;

    localparam int NB       = 32;
    localparam int PW       = 16;
    localparam int MINP     = 128;
    localparam int MAXP     = 8000;
    localparam int IW       = $clog2(NB);
    localparam int HALL_LAT = 3;
    localparam int HALL_W   = 20;

    logic          clk = 1'b0;
    logic          nrst;
    logic          hall_sensor;
    logic          slice_done;
    logic          position_sync;
    logic [IW-1:0] slice_index;
    logic          rotation_locked;
    logic [PW-1:0] rotation_period;
    logic [15:0]   overrun_count;

    slice_scheduler #(
        .NB_SLICES  (NB),
        .PERIOD_W   (PW),
        .MIN_PERIOD (MINP),
        .MAX_PERIOD (MAXP)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .hall_sensor     (hall_sensor),
        .slice_done      (slice_done),
`ifdef SLICE_SCHEDULER_PHASE_OFFSET_EN
        .phase_offset    ('0),
`endif
        .position_sync   (position_sync),
        .slice_index     (slice_index),
        .rotation_locked (rotation_locked),
        .rotation_period (rotation_period),
        .overrun_count   (overrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int idx;
    } ev_t;

    ev_t obs[$];
    ev_t expq[$];
    int  syncs[$];
    int  cyc        = 0;
    int  checks     = 0;
    int  errors     = 0;
    int  hall_high  = 0;
    bit  resp_en    = 1'b0;
    bit  last_pulse = 1'b0;
    bit  model_idle = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock cycle: sample at the falling edge, then drive the responder and hall input.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (position_sync === 1'b1) obs.push_back('{t: cyc, idx: int'(slice_index)});
        if (resp_en) slice_done = last_pulse;
        last_pulse = (position_sync === 1'b1);
        if (hall_high > 0) begin
            hall_high--;
            if (hall_high == 0) hall_sensor = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic hall_edge();
        int s;
        hall_sensor = 1'b1;
        hall_high   = HALL_W;
        s = cyc + 1 + HALL_LAT;
        if (model_idle) begin
            model_idle = 1'b0;
            syncs.push_back(s);
        end else if (s - syncs[$] >= MINP) begin
            syncs.push_back(s);
        end
    endtask

    task automatic revolution(input int period);
        hall_edge();
        run(period);
    endtask

    // Slice k of a revolution lands ceil(k*P/NB) cycles after its sync, P being the previous revolution's length.
    function automatic void build_expected(input int end_cyc);
        expq.delete();
        for (int i = 1; i < syncs.size(); i++) begin
            int p;
            int nxt;
            p   = syncs[i] - syncs[i-1];
            nxt = (i + 1 < syncs.size()) ? syncs[i+1] : end_cyc + 1;
            expq.push_back('{t: syncs[i], idx: 0});
            for (int k = 1; k < NB; k++) begin
                int t;
                t = syncs[i] + (k * p + NB - 1) / NB;
                if (t < nxt) expq.push_back('{t: t, idx: k});
            end
        end
    endfunction

    function automatic int model_overruns();
        int n = 0;
        for (int i = 1; i < expq.size(); i++) begin
            if (expq[i].t == expq[i-1].t + 1) n++;
        end
        return n;
    endfunction

    task automatic compare_lists(input string tag);
        int n;
        check({tag, " pulse count"}, 32'(obs.size()), 32'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s pulse %0d cycle", tag, i), obs[i].t, expq[i].t);
            check($sformatf("%s pulse %0d index", tag, i), obs[i].idx, expq[i].idx);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " position_sync"}, 32'(position_sync), 0);
        check({tag, " slice_index"}, 32'(slice_index), 0);
        check({tag, " rotation_locked"}, 32'(rotation_locked), 0);
        check({tag, " rotation_period"}, 32'(rotation_period), 0);
        check({tag, " overrun_count"}, 32'(overrun_count), 0);
    endtask

    initial begin
        int s_last;
        int s1;
        int base_ovr;

        nrst        = 1'b0;
        hall_sensor = 1'b0;
        slice_done  = 1'b0;
        #1;
        check_all_zero("reset");
        run(4);
        nrst = 1'b1;
        run(5);

        resp_en = 1'b1;
        revolution(3200);
        check("acquire locked", 32'(rotation_locked), 0);
        check("acquire pulses", 32'(obs.size()), 0);
        revolution(3200);
        revolution(3200);
        check("steady locked", 32'(rotation_locked), 1);
        check("steady period", 32'(rotation_period), 3200);

        repeat (3) revolution(1000);
        check("short period", 32'(rotation_period), 1000);
        repeat (3) revolution(int'($urandom_range(900, 3500)));

        revolution(2000);
        hall_edge();
        run(MINP - 1);
        hall_edge();
        run(2000 - (MINP - 1));
        hall_edge();
        run(10);
        check("glitch period", 32'(rotation_period), 2000);
        run(1990);

        hall_edge();
        run(2299);
        check("held index", 32'(slice_index), NB - 1);
        run(1);
        revolution(1700);

        hall_edge();
        s_last = syncs[$];
        run(s_last + MAXP - 1 - cyc);
        check("pre-timeout locked", 32'(rotation_locked), 1);
        tick();
        check("timeout locked", 32'(rotation_locked), 0);
        check("timeout index", 32'(slice_index), 0);
        check("timeout period kept", 32'(rotation_period), 1700);
        model_idle = 1'b1;
        build_expected(cyc);
        compare_lists("runA");
        base_ovr = model_overruns();
        check("runA overrun", 32'(overrun_count), base_ovr);

        resp_en    = 1'b0;
        slice_done = 1'b0;
        obs.delete();
        syncs.delete();
        revolution(3200);
        hall_edge();
        s1 = syncs[$];
        run(s1 + 250 - cyc);
        check("withheld overrun", 32'(overrun_count), base_ovr + 2);
        run(s1 + 300 - cyc);
        slice_done = 1'b1;
        tick();
        slice_done = 1'b0;
        run(s1 + 410 - cyc);
        slice_done = 1'b1;
        tick();
        slice_done = 1'b0;
        run(s1 + 550 - cyc);
        check("coincident overrun", 32'(overrun_count), base_ovr + 4);
        check("slice 5 cycle", (obs.size() > 5) ? obs[5].t : -1, s1 + 500);

        run(s1 + 1234 - cyc);
        #2 nrst = 1'b0;
        #1;
        check_all_zero("mid reset");
        tick();
        nrst       = 1'b1;
        model_idle = 1'b1;
        syncs.delete();
        run(5);
        revolution(3200);
        check("reacquire after 1 edge", 32'(rotation_locked), 0);
        hall_edge();
        run(10);
        check("reacquire after 2 edges", 32'(rotation_locked), 1);
        check("reacquire period", 32'(rotation_period), 3200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
